// File: rtl/led_pattern_engine.sv
// led_pattern_engine: prescaled LED pattern generator with rotate, blink, fixed, ping-pong and fill modes
module led_pattern_engine #(
  parameter int               WIDTH      = 8,
  parameter int               STEP_DIV   = 50_000_000,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] FIXED_PAT  = WIDTH'(8'hAA),
  parameter bit               ACTIVE_LOW = 1'b0
) (
  input  logic             clk_1,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             cycle_done
);
  localparam int CW = $clog2(STEP_DIV) + 4;
  typedef enum logic {UP, DN} dir_t;
  logic [CW-1:0]    cnt, lim;
  logic [WIDTH-1:0] pattern, nxt, rotl, rotr;
  logic [2:0]       mode_q;
  dir_t             dir, dir_nxt;
  logic             done;
  function automatic logic [WIDTH-1:0] seed_of(input logic [2:0] m, input logic [WIDTH-1:0] p);
    return m == 3'd3 ? FIXED_PAT : m == 3'd5 ? '0 : m >= 3'd6 ? p : SEED;
  endfunction
  assign lim  = (CW'(STEP_DIV) << speed) - 1'b1;
  assign rotl = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
  assign rotr = {pattern[0], pattern[WIDTH-1:1]};
  // A step only happens when neither a load nor a mode reload claims this edge
  assign tick = en && !load && mode == mode_q && cnt == lim;
  assign led  = ACTIVE_LOW ? ~pattern : pattern;
  always_comb begin
    nxt     = pattern;
    dir_nxt = dir;
    case (mode_q)
      3'd0: nxt = rotl;
      3'd1: nxt = rotr;
      3'd2: nxt = ~pattern;
      3'd3: nxt = FIXED_PAT;
      3'd4: begin
        if (dir == UP) begin
          dir_nxt = pattern[WIDTH-1] ? DN : UP;
          nxt     = pattern[WIDTH-1] ? rotr : rotl;
        end else begin
          dir_nxt = pattern[0] ? UP : DN;
          nxt     = pattern[0] ? rotl : rotr;
        end
      end
      3'd5: nxt = &pattern ? '0 : {pattern[WIDTH-2:0], 1'b1};
      default: nxt = pattern;
    endcase
    done = mode_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} && nxt == seed_of(mode_q, pattern);
  end
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      pattern    <= SEED;
      mode_q     <= 3'd0;
      dir        <= UP;
      cnt        <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (load) begin
        pattern <= load_val;
        cnt     <= '0;
        dir     <= UP;
      end else if (mode != mode_q) begin
        mode_q  <= mode;
        pattern <= seed_of(mode, pattern);
        cnt     <= '0;
        dir     <= UP;
      end else if (en) begin
        cnt <= cnt >= lim ? '0 : cnt + 1'b1;
        if (tick) begin
          pattern    <= nxt;
          dir        <= dir_nxt;
          cycle_done <= done;
        end
      end
    end
  end
endmodule
